call_return_ctrl: RTL and testbench
===================================

Name: call_return_ctrl

Overview:
- Initiator side of the stack interface. Turns CALL/RET requests from the instruction decoder into phased push/pop strobes.
- Owns the 2-bit `count` phase counter that the stack samples:
  - push is committed on a clock edge where count==1;
  - pop is committed on a clock edge where count==0.
- Returns the target or popped return address to the PC logic as a one-cycle load pulse.
- Tracks stack depth and flags overflow and underflow.

Parameters:
- DW, 16, data/address width of the pushed and popped words.
- DEPTH, 11, usable stack entries; the maximum depth before overflow.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- call  input  1  decoder request: push ret_addr, then jump to target. Sampled only when busy==0.
- ret  input  1  decoder request: pop and jump to the popped address. Sampled only when busy==0.
- ret_addr  input  DW  return address (PC+1), captured on call acceptance.
- target  input  DW  call destination, captured on call acceptance.
- stack_rdata  input  DW  stack data_out; valid in the cycle after a pop edge.
- push  output  1  to stack; asserted only while count==1.
- pop  output  1  to stack; asserted only while count==0.
- stack_wdata  output  DW  to stack data_in; holds the captured ret_addr.
- count  output  2  free-running phase counter to stack.
- pc_load  output  1  one-cycle pulse: the PC must load pc_next.
- pc_next  output  DW  new PC value; meaningful only while pc_load==1.
- busy  output  1  high from acceptance until the pc_load cycle inclusive.
- depth  output  4  current number of stacked entries, 0..DEPTH.
- overflow  output  1  sticky; set by a call issued at depth==DEPTH.
- underflow  output  1  sticky; set by a ret issued at depth==0.

Behaviour:
- Reset values: count=0, state=IDLE, push=pop=pc_load=busy=0, stack_wdata=0, pc_next=0, depth=0, overflow=underflow=0.
- rst asserted in any state aborts the operation in progress. No strobe or pc_load is issued in the reset cycle.
- count: increments by 1 every cycle, wrapping 3->0. It is never stalled by the state machine.
- push = (state==CALL_WAIT) && (count==1). pop = (state==RET_WAIT) && (count==0). These are decoded from registered state and count only; there is no combinational path from call or ret.
- States and transitions:
  - IDLE, call=1, depth<DEPTH: capture ret_addr into stack_wdata and target into a holding register. Go to CALL_WAIT.
  - IDLE, call=1, depth==DEPTH: set overflow. Stay IDLE. No push, no pc_load.
  - IDLE, ret=1 (call=0), depth>0: go to RET_WAIT.
  - IDLE, ret=1 (call=0), depth==0: set underflow. Stay IDLE.
  - IDLE, call=1 and ret=1 together: call wins; ret is dropped and no error is flagged.
  - CALL_WAIT: on the edge where push==1, depth+=1. Go to CALL_LOAD.
  - CALL_LOAD: pc_load=1, pc_next=held target. Next state IDLE.
  - RET_WAIT: on the edge where pop==1, depth-=1. Go to RET_LOAD.
  - RET_LOAD: pc_load=1, pc_next=stack_rdata (combinational pass-through). Next state IDLE.
- busy=1 in CALL_WAIT, CALL_LOAD, RET_WAIT and RET_LOAD. call and ret are ignored while busy, with no queueing.
- Latency, acceptance edge to pc_load cycle: 2..5 cycles depending on count phase.
  - Call accepted on an edge leaving count==0 has the minimum latency.
  - Ret accepted on an edge leaving count==3 has the minimum latency.
- A new request may be accepted on the edge that ends the pc_load cycle.
- Exactly one push or one pop per accepted request, never both in the same cycle.
- depth saturates at 0 and DEPTH by construction, since errored requests never enter the WAIT states.
- Sticky flags clear only on rst.
- The stack's own pointer reinitialisation is a system-level concern. This block's rst clears depth only.

Test Plan:
- Reset then idle 8 cycles -> count sequence 0,1,2,3,0,1,2,3; push=pop=pc_load=0; depth=0.
- call=1 for one cycle with ret_addr=0x0105, target=0x0200, accepted at count==0 -> push high for exactly the next count==1 cycle with stack_wdata=0x0105; next cycle pc_load=1, pc_next=0x0200; depth=1; busy low after.
- Following ret with the stack model returning 0x0105 -> pop high only in a count==0 cycle; next cycle pc_load=1, pc_next=0x0105; depth=0.
- 11 nested calls (targets 0x0300+i), then a 12th call -> overflow=1, no push or pc_load for the 12th. Then 11 rets return the addresses in LIFO order and depth reaches 0. A further ret -> underflow=1, no pop.
- call and ret both asserted in IDLE -> only push occurs, no pop, no error flag. call asserted while busy -> ignored; push count unchanged.
- rst asserted during CALL_WAIT, before count==1 -> no push follows, state IDLE, depth unchanged from 0, flags cleared, count restarts at 0.

Source files
------------

// File: rtl/call_return_ctrl.sv
// Call/return initiator for the hardware return stack.
// Phases push/pop strobes on the free-running count and loads the PC.
module call_return_ctrl #(
  parameter int DW    = 16,
  parameter int DEPTH = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          call,
  input  logic          ret,
  input  logic [DW-1:0] ret_addr,
  input  logic [DW-1:0] target,
  input  logic [DW-1:0] stack_rdata,
  output logic          push,
  output logic          pop,
  output logic [DW-1:0] stack_wdata,
  output logic [1:0]    count,
  output logic          pc_load,
  output logic [DW-1:0] pc_next,
  output logic          busy,
  output logic [3:0]    depth,
  output logic          overflow,
  output logic          underflow
);

  typedef enum logic [2:0] {
    IDLE,
    CALL_WAIT,
    CALL_LOAD,
    RET_WAIT,
    RET_LOAD
  } state_t;

  localparam logic [3:0] DMAX = 4'(DEPTH);

  state_t        state;
  logic [DW-1:0] tgt;

  // Strobes are masked during reset so nothing commits on a reset edge.
  assign push = !rst && (state == CALL_WAIT) && (count == 2'd1);
  assign pop  = !rst && (state == RET_WAIT)  && (count == 2'd0);

  assign pc_load = !rst &&
    ((state == CALL_LOAD) || (state == RET_LOAD));
  assign busy = (state != IDLE);

  always_comb begin
    pc_next = '0;
    if (state == CALL_LOAD) pc_next = tgt;
    if (state == RET_LOAD)  pc_next = stack_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      count       <= 2'd0;
      stack_wdata <= '0;
      tgt         <= '0;
      depth       <= 4'd0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      count <= count + 2'd1;
      case (state)
        CALL_WAIT: begin
          if (count == 2'd1) begin
            depth <= depth + 4'd1;
            state <= CALL_LOAD;
          end
        end
        RET_WAIT: begin
          if (count == 2'd0) begin
            depth <= depth - 4'd1;
            state <= RET_LOAD;
          end
        end
        default: begin
          // IDLE and the load cycles: a new request may start here.
          state <= IDLE;
          if (call) begin
            if (depth < DMAX) begin
              stack_wdata <= ret_addr;
              tgt         <= target;
              state       <= CALL_WAIT;
            end else begin
              overflow <= 1'b1;
            end
          end else if (ret) begin
            if (depth != 4'd0) begin
              state <= RET_WAIT;
            end else begin
              underflow <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_call_return_ctrl.sv
// Directed bench for call_return_ctrl with a cycle-indexed
// transaction model and a behavioural return stack.
module tb_call_return_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        call = 1'b0;
  logic        ret = 1'b0;
  logic [15:0] ret_addr = '0;
  logic [15:0] target = '0;
  logic [15:0] stack_rdata = '0;
  logic        push, pop, pc_load, busy;
  logic        overflow, underflow;
  logic [15:0] stack_wdata, pc_next;
  logic [1:0]  count;
  logic [3:0]  depth;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  call_return_ctrl #(.DW(16), .DEPTH(11)) dut (
    .clk(clk), .rst(rst), .call(call), .ret(ret),
    .ret_addr(ret_addr), .target(target),
    .stack_rdata(stack_rdata),
    .push(push), .pop(pop), .stack_wdata(stack_wdata),
    .count(count), .pc_load(pc_load), .pc_next(pc_next),
    .busy(busy), .depth(depth),
    .overflow(overflow), .underflow(underflow)
  );

  // Environment: the stack itself, driven by the DUT strobes.
  logic [15:0] mem [16];
  int sp = 0;
  int npush = 0;
  int npop = 0;
  always @(posedge clk) begin
    if (rst) begin
      sp = 0;
    end else begin
      if (push && sp < 16) begin
        mem[sp] = stack_wdata;
        sp++;
        npush++;
      end
      if (pop && sp > 0) begin
        sp--;
        npop++;
        stack_rdata <= mem[sp];
      end
    end
  end

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               n, act, exp, $time);
    end
  endtask

  // Model: cycles numbered from the last reset edge; a request
  // accepted at the end of cycle k strobes in the first later cycle
  // with the required phase and loads the PC one cycle after.
  bit          m_init = 0;
  int          cyc = 0;
  int          ev_acc = -1;
  int          ev_strobe = -1;
  int          ev_load = -1;
  bit          ev_call = 0;
  logic [15:0] ev_wdata = '0;
  logic [15:0] ev_pc = '0;
  int          mdepth = 0;
  bit          movf = 0;
  bit          mundf = 0;
  logic [15:0] mstk [$];

  function automatic int next_phase(int from, int ph);
    int j = from + 1;
    while (j % 4 != ph) j++;
    return j;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_init = 1;
      cyc = 0;
      ev_acc = -1;
      ev_strobe = -1;
      ev_load = -1;
      ev_wdata = '0;
      mdepth = 0;
      movf = 0;
      mundf = 0;
      mstk.delete();
    end else if (m_init) begin
      if (cyc == ev_strobe) begin
        if (ev_call) begin
          mstk.push_back(ev_wdata);
          mdepth++;
        end else begin
          mdepth--;
        end
      end
      if (cyc >= ev_load) begin
        if (call) begin
          if (mdepth < 11) begin
            ev_call = 1;
            ev_acc = cyc;
            ev_wdata = ret_addr;
            ev_pc = target;
            ev_strobe = next_phase(cyc, 1);
            ev_load = ev_strobe + 1;
          end else begin
            movf = 1;
          end
        end else if (ret) begin
          if (mdepth > 0) begin
            ev_call = 0;
            ev_acc = cyc;
            ev_pc = mstk.pop_back();
            ev_strobe = next_phase(cyc, 0);
            ev_load = ev_strobe + 1;
          end else begin
            mundf = 1;
          end
        end
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      if (rst) begin
        chk("rst_push", push, 0);
        chk("rst_pop", pop, 0);
        chk("rst_pc_load", pc_load, 0);
      end else begin
        chk("count", count, cyc % 4);
        chk("push", push, ev_call && cyc == ev_strobe);
        chk("pop", pop, !ev_call && cyc == ev_strobe);
        chk("pc_load", pc_load, cyc == ev_load);
        chk("busy", busy, cyc > ev_acc && cyc <= ev_load);
        chk("depth", depth, mdepth);
        chk("overflow", overflow, movf);
        chk("underflow", underflow, mundf);
        if (push) chk("wdata", stack_wdata, ev_wdata);
        if (cyc == ev_load) chk("pc_next", pc_next, ev_pc);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_count(logic [1:0] c);
    for (int i = 0; i < 4 && count != c; i++) tick();
  endtask

  task automatic req(bit c, bit r, logic [15:0] ra, logic [15:0] tg);
    call = c;
    ret = r;
    ret_addr = ra;
    target = tg;
    tick();
    call = 0;
    ret = 0;
  endtask

  task automatic wait_load(string n, logic [15:0] exp);
    bit seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      if (pc_load) begin
        seen = 1;
        chk(n, pc_next, exp);
      end else begin
        tick();
      end
    end
    if (!seen) begin
      nvec++;
      nerr++;
      $display("FAIL %s: no pc_load within 8 cycles", n);
    end
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  initial begin
    int p0;
    tick();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      chk("idle_count_lit", count, i % 4);
      tick();
    end

    wait_count(2'd0);
    req(1, 0, 16'h0105, 16'h0200);
    chk("push_at_cnt1_lit", {push, count}, 3'b101);
    chk("wdata_lit", stack_wdata, 16'h0105);
    wait_load("call_pc_lit", 16'h0200);
    chk("depth1_lit", depth, 1);
    tick();
    chk("busy_after_lit", busy, 0);

    req(0, 1, 16'h0, 16'h0);
    wait_load("ret_pc_lit", 16'h0105);
    chk("depth0_lit", depth, 0);
    tick();

    for (int i = 0; i < 11; i++) begin
      req(1, 0, 16'h0400 + 16'(i), 16'h0300 + 16'(i));
      wait_load("nest_call", 16'h0300 + 16'(i));
      tick();
    end
    chk("depth11_lit", depth, 11);
    p0 = npush;
    req(1, 0, 16'h0499, 16'h0399);
    repeat (6) tick();
    chk("overflow_lit", overflow, 1);
    chk("ovf_nopush", npush, p0);

    for (int i = 0; i < 11; i++) begin
      req(0, 1, 16'h0, 16'h0);
      wait_load("lifo_ret", 16'h040A - 16'(i));
      tick();
    end
    chk("depth_empty_lit", depth, 0);
    p0 = npop;
    req(0, 1, 16'h0, 16'h0);
    repeat (6) tick();
    chk("underflow_lit", underflow, 1);
    chk("unf_nopop", npop, p0);

    do_reset();
    chk("flags_clr_lit", {overflow, underflow}, 0);
    p0 = npop;
    req(1, 1, 16'h0777, 16'h0888);
    wait_load("both_pc", 16'h0888);
    chk("both_nopop", npop, p0);
    chk("both_noflag", {overflow, underflow}, 0);
    tick();

    p0 = npush;
    req(1, 0, 16'h0AAA, 16'h0BBB);
    req(1, 0, 16'h0CCC, 16'h0DDD);
    wait_load("busy_call_pc", 16'h0BBB);
    repeat (6) tick();
    chk("busy_ignored", npush, p0 + 1);
    chk("busy_depth_lit", depth, 2);

    do_reset();
    wait_count(2'd1);
    p0 = npush;
    req(1, 0, 16'h0123, 16'h0456);
    chk("in_wait_busy_lit", busy, 1);
    rst = 1;
    tick();
    rst = 0;
    chk("rst_cnt_lit", count, 0);
    chk("rst_busy_lit", busy, 0);
    repeat (6) tick();
    chk("rst_nopush", npush, p0);
    chk("rst_depth_lit", depth, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
